rf_access_arbiter: RTL and testbench

- Shares the single-write/single-read 8x8 register file among NREQ requesters using round-robin arbitration with a valid/ready handshake.
- Accepts one request per cycle and drives the register file's write/read strobes, addresses and data from a registered issue stage.
- Returns read data with a requester tag.
- Sits between the datapath requesters (e.g. ALU writeback, load unit, debug port) and the register file.

---
 rtl/rf_access_arbiter.sv | 142 ++++++++++++++
 tb/tb_rf_access_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_access_arbiter.sv
// Round-robin valid/ready arbiter sharing one 1W/1R register file among NREQ requesters.
// Optional grant locking is compiled in with `define RFARB_LOCK_EN.
module rf_access_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DW   = 8,
  parameter int unsigned AW   = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_write,
  input  logic [NREQ*AW-1:0]       req_addr,
  input  logic [NREQ*DW-1:0]       req_wdata,
  input  logic [NREQ-1:0]          req_lock,
  output logic [NREQ-1:0]          req_ready,
  output logic                     rf_WE,
  output logic [AW-1:0]            rf_WA,
  output logic [DW-1:0]            rf_I,
  output logic                     rf_RE,
  output logic [AW-1:0]            rf_RA,
  input  logic [DW-1:0]            rf_O,
  output logic                     rsp_valid,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [DW-1:0]            rsp_data
);

  localparam int unsigned IDW = $clog2(NREQ);

  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  ptr_nxt;
  logic [IDW-1:0]  gnt_idx;
  logic            accept;
  logic [NREQ-1:0] elig;
  logic            sel_write;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;

  logic            cmd_valid;
  logic            cmd_write;
  logic [IDW-1:0]  cmd_id;

`ifdef RFARB_LOCK_EN
  typedef enum logic {UNLOCKED, LOCKED} lock_state_t;

  lock_state_t    lock_state, lock_state_nxt;
  logic [IDW-1:0] owner, owner_nxt;

  // While locked only the owner is eligible, even when it is idle.
  assign elig = (lock_state == LOCKED) ? (req_valid & (NREQ'(1) << owner)) : req_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_state <= UNLOCKED;
      owner      <= '0;
    end else begin
      lock_state <= lock_state_nxt;
      owner      <= owner_nxt;
    end
  end

  always_comb begin
    lock_state_nxt = lock_state;
    owner_nxt      = owner;
    if (accept) begin
      if (req_lock[gnt_idx]) begin
        lock_state_nxt = LOCKED;
        owner_nxt      = gnt_idx;
      end else begin
        lock_state_nxt = UNLOCKED;
      end
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^req_lock;
  assign elig        = req_valid;
`endif

  // Rotating priority search starting at ptr.
  always_comb begin : arb
    int unsigned j;
    req_ready = '0;
    gnt_idx   = '0;
    accept    = 1'b0;
    j         = 0;
    if (!rst) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        j = 32'(ptr) + i;
        if (j >= NREQ) j = j - NREQ;
        if (!accept && elig[IDW'(j)]) begin
          accept              = 1'b1;
          gnt_idx             = IDW'(j);
          req_ready[IDW'(j)]  = 1'b1;
        end
      end
    end
  end

  assign ptr_nxt   = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
  assign sel_write = req_write[gnt_idx];
  assign sel_addr  = req_addr[gnt_idx*AW +: AW];
  assign sel_wdata = req_wdata[gnt_idx*DW +: DW];

  // Strobes are gated by rst so an in-flight command never reaches the register file.
  assign rf_WE = cmd_valid &  cmd_write & ~rst;
  assign rf_RE = cmd_valid & ~cmd_write & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      cmd_valid <= 1'b0;
      cmd_write <= 1'b0;
      cmd_id    <= '0;
      rf_WA     <= '0;
      rf_I      <= '0;
      rf_RA     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      cmd_valid <= accept;
      if (accept) begin
        ptr       <= ptr_nxt;
        cmd_write <= sel_write;
        cmd_id    <= gnt_idx;
        // Address/data registers only load for their own direction, so idle cycles hold them.
        if (sel_write) begin
          rf_WA <= sel_addr;
          rf_I  <= sel_wdata;
        end else begin
          rf_RA <= sel_addr;
        end
      end
      rsp_valid <= rf_RE;
      if (rf_RE) begin
        rsp_data <= rf_O;
        rsp_id   <= cmd_id;
      end
    end
  end

endmodule

// File: tb/tb_rf_access_arbiter.sv
// Directed bench for rf_access_arbiter with a behavioural 8x8 register file.
// Lock scenario is exercised when RFARB_LOCK_EN is defined.
module tb_rf_access_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned DW   = 8;
  localparam int unsigned AW   = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_write;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]   req_lock;
  logic [NREQ-1:0]   req_ready;
  logic              rf_WE;
  logic [AW-1:0]     rf_WA;
  logic [DW-1:0]     rf_I;
  logic              rf_RE;
  logic [AW-1:0]     rf_RA;
  logic [DW-1:0]     rf_O;
  logic              rsp_valid;
  logic [1:0]        rsp_id;
  logic [DW-1:0]     rsp_data;

  logic [DW-1:0] rf_mem [8];

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rf_access_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_lock  (req_lock),
    .req_ready (req_ready),
    .rf_WE     (rf_WE),
    .rf_WA     (rf_WA),
    .rf_I      (rf_I),
    .rf_RE     (rf_RE),
    .rf_RA     (rf_RA),
    .rf_O      (rf_O),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data)
  );

  always @(posedge clk) if (rf_WE) rf_mem[rf_WA] <= rf_I;
  assign rf_O = rf_RE ? rf_mem[rf_RA] : '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic v, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic l);
    req_valid[k]          = v;
    req_write[k]          = w;
    req_addr[k*AW +: AW]  = a;
    req_wdata[k*DW +: DW] = d;
    req_lock[k]           = l;
  endtask

  task automatic clear_reqs();
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_lock  = '0;
  endtask

  initial begin
    rst = 1'b1;
    clear_reqs();
    tick();
    // Reset: requests visible but nothing granted or strobed.
    req_valid = 4'b1111;
    #1;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_we", 32'(rf_WE), 32'h0);
    chk("rst_re", 32'(rf_RE), 32'h0);
    tick();
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_id", 32'(rsp_id), 32'h0);
    chk("rst_rsp_data", 32'(rsp_data), 32'h0);
    rst = 1'b0;
    clear_reqs();

    // Write then read back addr 5.
    set_req(0, 1'b1, 1'b1, 3'd5, 8'hA5, 1'b0);
    #1;
    chk("t1_wr_ready", 32'(req_ready), 32'h1);
    tick();
    clear_reqs();
    chk("t1_we", 32'(rf_WE), 32'h1);
    chk("t1_wa", 32'(rf_WA), 32'h5);
    chk("t1_i", 32'(rf_I), 32'hA5);
    chk("t1_re_idle", 32'(rf_RE), 32'h0);
    tick();
    chk("t1_we_idle", 32'(rf_WE), 32'h0);
    set_req(0, 1'b1, 1'b0, 3'd5, 8'h00, 1'b0);
    #1;
    chk("t1_rd_ready", 32'(req_ready), 32'h1);
    tick();
    clear_reqs();
    chk("t1_re", 32'(rf_RE), 32'h1);
    chk("t1_ra", 32'(rf_RA), 32'h5);
    chk("t1_we_rd", 32'(rf_WE), 32'h0);
    chk("t1_rsp_early", 32'(rsp_valid), 32'h0);
    tick();
    chk("t1_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("t1_rsp_id", 32'(rsp_id), 32'h0);
    chk("t1_rsp_data", 32'(rsp_data), 32'hA5);
    tick();
    chk("t1_rsp_pulse", 32'(rsp_valid), 32'h0);

    // Return ptr to 0, then all four requesters read continuously.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) begin
        for (int k = 0; k < 4; k++) set_req(k, 1'b1, 1'b0, 3'd5, 8'h00, 1'b0);
      end else begin
        clear_reqs();
      end
      #1;
      chk($sformatf("t2_ready_%0d", i), 32'(req_ready), (i < 8) ? (32'h1 << (i % 4)) : 32'h0);
      if (i >= 2) begin
        chk($sformatf("t2_rsp_valid_%0d", i), 32'(rsp_valid), 32'h1);
        chk($sformatf("t2_rsp_id_%0d", i), 32'(rsp_id), 32'((i - 2) % 4));
        chk($sformatf("t2_rsp_data_%0d", i), 32'(rsp_data), 32'hA5);
      end
      tick();
    end
    chk("t2_rsp_done", 32'(rsp_valid), 32'h0);

    // Write addr 3 then read it the very next cycle (ptr = 0).
    set_req(1, 1'b1, 1'b1, 3'd3, 8'h3C, 1'b0);
    #1;
    chk("t3_wr_ready", 32'(req_ready), 32'h2);
    tick();
    clear_reqs();
    set_req(2, 1'b1, 1'b0, 3'd3, 8'h00, 1'b0);
    #1;
    chk("t3_rd_ready", 32'(req_ready), 32'h4);
    chk("t3_we", 32'(rf_WE), 32'h1);
    chk("t3_wa", 32'(rf_WA), 32'h3);
    tick();
    clear_reqs();
    chk("t3_re", 32'(rf_RE), 32'h1);
    chk("t3_ra", 32'(rf_RA), 32'h3);
    tick();
    chk("t3_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("t3_rsp_id", 32'(rsp_id), 32'h2);
    chk("t3_rsp_data", 32'(rsp_data), 32'h3C);
    tick();

    // Seed reg 7, then a write to 7 is dropped by reset in its issue cycle (ptr = 3).
    set_req(3, 1'b1, 1'b1, 3'd7, 8'h77, 1'b0);
    #1;
    chk("t4_seed_ready", 32'(req_ready), 32'h8);
    tick();
    clear_reqs();
    tick();
    set_req(0, 1'b1, 1'b1, 3'd7, 8'hEE, 1'b0);
    #1;
    chk("t4_wr_ready", 32'(req_ready), 32'h1);
    tick();
    clear_reqs();
    rst = 1'b1;
    #1;
    chk("t4_we_dropped", 32'(rf_WE), 32'h0);
    tick();
    rst = 1'b0;
    chk("t4_rsp_valid", 32'(rsp_valid), 32'h0);
    set_req(0, 1'b1, 1'b0, 3'd7, 8'h00, 1'b0);
    set_req(1, 1'b1, 1'b0, 3'd7, 8'h00, 1'b0);
    #1;
    chk("t4_ready_after_rst", 32'(req_ready), 32'h1);
    tick();
    clear_reqs();
    tick();
    chk("t4_rsp_valid2", 32'(rsp_valid), 32'h1);
    chk("t4_rsp_id", 32'(rsp_id), 32'h0);
    chk("t4_reg7_kept", 32'(rsp_data), 32'h77);
    tick();

    // Only requester 2 valid for four cycles (ptr = 1).
    for (int i = 0; i < 4; i++) begin
      set_req(2, 1'b1, 1'b0, 3'd3, 8'h00, 1'b0);
      #1;
      chk($sformatf("t5_ready_%0d", i), 32'(req_ready), 32'h4);
      tick();
    end
    for (int k = 0; k < 4; k++) set_req(k, 1'b1, 1'b0, 3'd3, 8'h00, 1'b0);
    #1;
    chk("t5_ptr_is_3", 32'(req_ready), 32'h8);
    tick();
    clear_reqs();
    tick();
    tick();

`ifdef RFARB_LOCK_EN
    // ptr = 0: req 0 first, then req 1 locks and holds the grant.
    set_req(0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
    set_req(1, 1'b1, 1'b0, 3'd0, 8'h00, 1'b1);
    set_req(2, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
    #1;
    chk("t6_ready0", 32'(req_ready), 32'h1);
    tick();
    chk("t6_lock_grant", 32'(req_ready), 32'h2);
    tick();
    chk("t6_locked_hold", 32'(req_ready), 32'h2);
    tick();
    req_valid[1] = 1'b0;
    #1;
    chk("t6_owner_idle_stall", 32'(req_ready), 32'h0);
    tick();
    set_req(1, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
    #1;
    chk("t6_unlock_xfer", 32'(req_ready), 32'h2);
    tick();
    chk("t6_after_unlock", 32'(req_ready), 32'h4);
    tick();
    clear_reqs();
    tick();
    tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
